// File: rtl/mc_pkg.sv
// Shared types for the multi-channel counter: per-channel terminal behaviour.
package mc_pkg;

   typedef enum logic [1:0] {
      MODE_SAT     = 2'b00,
      MODE_WRAP    = 2'b01,
      MODE_ONESHOT = 2'b10,
      MODE_HOLD    = 2'b11
   } mode_t;

endpackage

// File: rtl/multi_counter_count_channel.sv
// One N-bit counter channel: step/clear/load with saturate, wrap, one-shot and hold
// behaviour at the terminal value.
module count_channel
   import mc_pkg::*;
#(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         nrst,
   input  logic         tick,
   input  logic         en,
   input  logic         clear,
   input  logic         load,
   input  logic [N-1:0] load_val,
   input  logic         dir,
   input  mode_t        mode,
   input  logic [N-1:0] max,
   output logic [N-1:0] count,
   output logic         at_term,
   output logic         tc_pulse,
   output logic         done
);

   logic [N-1:0] r_count;
   logic         r_tc;
   logic         r_done;
   logic [N-1:0] w_nxt_count;
   logic         w_nxt_tc;
   logic         w_nxt_done;
   logic         w_step;
   logic         w_at_term;

   // Terminal: up uses >= so a max lowered beneath the count still terminates.
   always_comb begin
      if (dir) begin
         w_at_term = (r_count >= max);
      end else begin
         w_at_term = (r_count == {N{1'b0}});
      end
   end

   assign w_step = en & tick & ~r_done & (mode != MODE_HOLD);

   // Next-state selection with clear > load > step > hold priority.
   always_comb begin
      w_nxt_count = r_count;
      w_nxt_tc    = 1'b0;
      w_nxt_done  = r_done;
      if (clear) begin
         w_nxt_count = {N{1'b0}};
         w_nxt_done  = 1'b0;
      end else if (load) begin
         w_nxt_count = load_val;
         w_nxt_done  = 1'b0;
      end else if (w_step) begin
         if (!w_at_term) begin
            if (dir) begin
               w_nxt_count = r_count + 1'b1;
            end else begin
               w_nxt_count = r_count - 1'b1;
            end
         end else begin
            case (mode)
               MODE_SAT: begin
                  w_nxt_tc = 1'b1;
               end
               MODE_WRAP: begin
                  w_nxt_tc    = 1'b1;
                  w_nxt_count = dir ? {N{1'b0}} : max;
               end
               MODE_ONESHOT: begin
                  w_nxt_tc   = 1'b1;
                  w_nxt_done = 1'b1;
               end
               default: begin
                  w_nxt_count = r_count;
               end
            endcase
         end
      end else begin
         w_nxt_count = r_count;
      end
   end

   // Channel state registers.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_count <= {N{1'b0}};
         r_tc    <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_count <= w_nxt_count;
         r_tc    <= w_nxt_tc;
         r_done  <= w_nxt_done;
      end
   end

   assign count    = r_count;
   assign at_term  = w_at_term;
   assign tc_pulse = r_tc;
   assign done     = r_done;

endmodule

// File: rtl/multi_counter.sv
// CH independent counters sharing a prescaled tick, a prescale setting and a load value.
module multi_counter
   import mc_pkg::*;
#(
   parameter int N  = 8,
   parameter int CH = 4,
   parameter int PW = 4
) (
   input  logic            clk,
   input  logic            nrst,
   input  logic [PW-1:0]   prescale,
   input  logic [CH-1:0]   en,
   input  logic [CH-1:0]   clear,
   input  logic [CH-1:0]   load,
   input  logic [N-1:0]    load_val,
   input  logic [CH-1:0]   dir,
   input  logic [2*CH-1:0] mode,
   input  logic [N*CH-1:0] max,
   output logic [N*CH-1:0] count,
   output logic [CH-1:0]   at_term,
   output logic [CH-1:0]   tc_pulse,
   output logic [CH-1:0]   done
);

   logic [PW-1:0] r_pcnt;
   logic          w_tick;

   // Lowering prescale below pcnt simply lets pcnt run on through the wrap to 0.
   assign w_tick = (r_pcnt == prescale);

   // Free-running prescaler.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_pcnt <= {PW{1'b0}};
      end else if (w_tick) begin
         r_pcnt <= {PW{1'b0}};
      end else begin
         r_pcnt <= r_pcnt + 1'b1;
      end
   end

   for (genvar gi = 0; gi < CH; gi++) begin : g_ch
      count_channel #(
         .N (N)
      ) u_ch (
         .clk      (clk),
         .nrst     (nrst),
         .tick     (w_tick),
         .en       (en[gi]),
         .clear    (clear[gi]),
         .load     (load[gi]),
         .load_val (load_val),
         .dir      (dir[gi]),
         .mode     (mode_t'(mode[2*gi +: 2])),
         .max      (max[gi*N +: N]),
         .count    (count[gi*N +: N]),
         .at_term  (at_term[gi]),
         .tc_pulse (tc_pulse[gi]),
         .done     (done[gi])
      );
   end

endmodule

// File: tb/tb_multi_counter.sv
// Directed bench for multi_counter with N=4, CH=4, PW=4.
module tb_multi_counter;

   logic        clk;
   logic        nrst;
   logic [3:0]  prescale;
   logic [3:0]  en, clear, load, dir;
   logic [3:0]  load_val;
   logic [7:0]  mode;
   logic [15:0] max;
   logic [15:0] count;
   logic [3:0]  at_term, tc_pulse, done;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [3:0]  clr, ld, en, dir;
      logic [7:0]  mode;
      logic [15:0] mx;
      logic [3:0]  lv;
      logic [15:0] ec;
      logic [3:0]  etc, eat;
   } vec_t;

   vec_t tv [18];

   multi_counter #(.N(4), .CH(4), .PW(4)) dut (
      .clk      (clk),
      .nrst     (nrst),
      .prescale (prescale),
      .en       (en),
      .clear    (clear),
      .load     (load),
      .load_val (load_val),
      .dir      (dir),
      .mode     (mode),
      .max      (max),
      .count    (count),
      .at_term  (at_term),
      .tc_pulse (tc_pulse),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic edge_wait();
      @(posedge clk);
      #1;
   endtask

   initial begin
      nrst = 1'b0; prescale = 4'd0; en = 4'h0; clear = 4'h0; load = 4'h0;
      dir = 4'hF; load_val = 4'h0; mode = 8'h01; max = 16'hFFF5;
      #1;
      chk("reset_count", 32'(count), 32'h0);
      chk("reset_tc",    32'(tc_pulse), 32'h0);
      chk("reset_done",  32'(done), 32'h0);
      @(negedge clk);
      nrst = 1'b1;

      //          clr   ld    en    dir   mode   mx         lv    ec         etc   eat
      tv[0]  = '{4'h0, 4'h0, 4'h1, 4'hF, 8'h01, 16'hFFF5, 4'h0, 16'h0001, 4'h0, 4'h0};
      tv[1]  = '{4'h0, 4'h0, 4'h1, 4'hF, 8'h01, 16'hFFF5, 4'h0, 16'h0002, 4'h0, 4'h0};
      tv[2]  = '{4'h0, 4'h0, 4'h1, 4'hF, 8'h01, 16'hFFF5, 4'h0, 16'h0003, 4'h0, 4'h0};
      tv[3]  = '{4'h0, 4'h0, 4'h1, 4'hF, 8'h01, 16'hFFF5, 4'h0, 16'h0004, 4'h0, 4'h0};
      tv[4]  = '{4'h0, 4'h0, 4'h1, 4'hF, 8'h01, 16'hFFF5, 4'h0, 16'h0005, 4'h0, 4'h1};
      tv[5]  = '{4'h0, 4'h0, 4'h1, 4'hF, 8'h01, 16'hFFF5, 4'h0, 16'h0000, 4'h1, 4'h0};
      tv[6]  = '{4'h0, 4'h0, 4'h1, 4'hF, 8'h01, 16'hFFF5, 4'h0, 16'h0001, 4'h0, 4'h0};
      tv[7]  = '{4'h8, 4'h8, 4'h1, 4'hF, 8'h01, 16'hFFF5, 4'h9, 16'h0002, 4'h0, 4'h0};
      tv[8]  = '{4'h0, 4'h8, 4'h1, 4'hF, 8'h01, 16'hFFF5, 4'h9, 16'h9003, 4'h0, 4'h0};
      tv[9]  = '{4'h8, 4'h8, 4'h1, 4'hF, 8'h01, 16'hFFF5, 4'h9, 16'h0004, 4'h0, 4'h0};
      tv[10] = '{4'h0, 4'h1, 4'h1, 4'hF, 8'h01, 16'hFFF5, 4'h7, 16'h0007, 4'h0, 4'h1};
      tv[11] = '{4'h0, 4'h0, 4'h1, 4'hF, 8'h01, 16'hFFF4, 4'h0, 16'h0000, 4'h1, 4'h0};
      tv[12] = '{4'h0, 4'h0, 4'h0, 4'hF, 8'h01, 16'hFFF4, 4'h0, 16'h0000, 4'h0, 4'h0};
      tv[13] = '{4'h0, 4'h0, 4'h1, 4'hE, 8'h01, 16'hFFF4, 4'h0, 16'h0004, 4'h1, 4'h0};
      tv[14] = '{4'h0, 4'h0, 4'h1, 4'hE, 8'h01, 16'hFFF4, 4'h0, 16'h0003, 4'h0, 4'h0};
      tv[15] = '{4'h0, 4'h1, 4'h0, 4'hF, 8'h00, 16'hFFF4, 4'h4, 16'h0004, 4'h0, 4'h1};
      tv[16] = '{4'h0, 4'h0, 4'h1, 4'hF, 8'h00, 16'hFFF4, 4'h0, 16'h0004, 4'h1, 4'h1};
      tv[17] = '{4'h0, 4'h0, 4'h1, 4'hF, 8'h03, 16'hFFF4, 4'h0, 16'h0004, 4'h0, 4'h1};

      for (int i = 0; i < 18; i++) begin
         clear = tv[i].clr; load = tv[i].ld; en = tv[i].en; dir = tv[i].dir;
         mode = tv[i].mode; max = tv[i].mx; load_val = tv[i].lv;
         edge_wait();
         chk($sformatf("vec%0d_count", i), 32'(count), 32'(tv[i].ec));
         chk($sformatf("vec%0d_tc", i), 32'(tc_pulse), 32'(tv[i].etc));
         chk($sformatf("vec%0d_at_term", i), 32'(at_term), 32'(tv[i].eat));
         chk($sformatf("vec%0d_done", i), 32'(done), 32'h0);
      end

      // ch2 down one-shot from 2
      en = 4'h0; load = 4'h0; clear = 4'hF;
      edge_wait();
      chk("os_clear_all", 32'(count), 32'h0);
      clear = 4'h0; load = 4'h4; load_val = 4'h2; dir = 4'hB; mode = 8'h20; max = 16'hFFFF;
      edge_wait();
      chk("os_load", 32'(count), 32'h0200);
      load = 4'h0; en = 4'h4;
      edge_wait();
      chk("os_cnt1", 32'(count), 32'h0100);
      edge_wait();
      chk("os_cnt0", 32'(count), 32'h0000);
      chk("os_no_done_yet", 32'(done), 32'h0);
      edge_wait();
      chk("os_term_count", 32'(count), 32'h0000);
      chk("os_term_tc", 32'(tc_pulse), 32'h4);
      chk("os_term_done", 32'(done), 32'h4);
      edge_wait();
      chk("os_blocked_count", 32'(count), 32'h0000);
      chk("os_blocked_tc", 32'(tc_pulse), 32'h0);
      chk("os_sticky_done", 32'(done), 32'h4);
      clear = 4'h4;
      edge_wait();
      chk("os_clear_done", 32'(done), 32'h0);
      clear = 4'h0;

      // async reset mid-count on all channels
      en = 4'hF; dir = 4'hF; mode = 8'h55; max = 16'hFFFF; prescale = 4'd0;
      edge_wait(); edge_wait(); edge_wait();
      chk("pre_reset_count", 32'(count), 32'h3333);
      #2;
      nrst = 1'b0;
      #1;
      chk("async_reset_count", 32'(count), 32'h0);
      chk("async_reset_tc", 32'(tc_pulse), 32'h0);
      chk("async_reset_done", 32'(done), 32'h0);

      // ch1 up saturate, prescale=2, from reset release
      prescale = 4'd2; en = 4'h2; mode = 8'h00; max = 16'hFF3F;
      @(negedge clk);
      nrst = 1'b1;
      for (int k = 1; k <= 15; k++) begin
         int exp_c;
         edge_wait();
         exp_c = (k / 3 > 3) ? 3 : k / 3;
         chk($sformatf("ps_count_k%0d", k), 32'(count[7:4]), 32'(exp_c));
         chk($sformatf("ps_tc_k%0d", k), 32'(tc_pulse[1]), (k % 3 == 0 && k >= 12) ? 32'd1 : 32'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
